rom_burst_reader: RTL and testbench
===================================

# rom_burst_reader

Parametrised synchronous lookup ROM with a burst read engine: accepts a start address and burst length over a valid/ready request channel, then streams consecutive words on a valid/ready output channel with backpressure. It is the next generation of the team's combinational address-to-data ROM exercises, generalised in address and data width and given registered, flow-controlled sequential reads. It sits between a controller (sequencer or testbench driver) and any data consumer.

## Interface
- `ADDR_W`, 4, address width; depth = 2^ADDR_W words.
- `DATA_W`, 8, word width.
- `LEN_W`, 4, burst length field width.
- `INIT_FILE`, "", hex file for `$readmemh`. If empty, `mem[a] = (3*a + 1) mod 2^DATA_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  engine can accept a request.
- `req_addr`  in  ADDR_W  burst start address.
- `req_len`  in  LEN_W  burst length minus one; 0 means 1 word, 2^LEN_W−1 means 2^LEN_W words.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  ROM word.
- `out_last`  out  1  final word of the burst.
- `busy`  out  1  a burst is in progress (state ≠ IDLE).

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch addr and len into the current-address register and remaining-count register, then go to STREAM.
  - STREAM: output register holds `mem[cur]`. `out_valid`=1 and `out_last`=1 when remaining = 0.
    - Beat handshake (`out_valid`&&`out_ready`) when not last: `cur` ← `cur+1`, remaining ← remaining−1, and the output register loads the next word on the same edge.
    - Beat handshake on the last word: go to IDLE.
  - No handshake: all outputs hold stable.
- `req_ready` is 0 in STREAM. Requests are never queued.
- Address arithmetic is modulo 2^ADDR_W, so a burst wraps from 2^ADDR_W−1 to 0.
- `req_addr` and `req_len` are sampled only on the request handshake. Later changes have no effect on the burst.
- `out_data` is don't-care when `out_valid`=0 and is driven as 0.
- ROM contents are read-only. No write port.

## Timing
- Reset values: `req_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, state IDLE.
- Request accepted at edge N → `out_valid`=1 with first word after edge N (visible in cycle N+1). Latency is 1 cycle.
- With `out_ready` held high, a burst of L words occupies L consecutive cycles. After the last handshake there is exactly one IDLE cycle before the next request can be accepted.
- `rst` asserted mid-burst: at the next edge all outputs return to reset values and the burst is discarded. No `out_last` is produced.
- `rst` has priority over simultaneous `req_valid` or `out_ready`.

## Configuration
- `ROM_PARITY_EN` defined:
  - Adds output `out_par` (1 bit), the even parity (XOR reduction) of the word currently in the output register.
  - It is registered together with `out_data` and resets to 0.
- Undefined: the port `out_par` and its logic are absent. Other behaviour is identical.

## Test plan
- Reset then single read: default params, no INIT_FILE. Request addr=5, len=0 → one cycle later `out_valid`=1, `out_data`=0x10, `out_last`=1. After the handshake, `busy`=0 and `req_ready`=1.
- Sequential burst: addr=0, len=7, `out_ready`=1 → 8 consecutive beats with data 0x01,0x04,0x07,0x0A,0x0D,0x10,0x13,0x16. `out_last` is high only on 0x16.
- Wrap-around: addr=14, len=3 → data 0x2B,0x2E,0x01,0x04 (addresses 14,15,0,1).
- Backpressure: addr=2, len=2. Drop `out_ready` for 3 cycles on the second beat → `out_data` stays 0x0A and `out_valid` stays 1 throughout. The burst completes with 0x0A then 0x0D and no lost or duplicated words. A `req_valid` pulse during the burst is ignored (`req_ready`=0).
- Reset mid-burst: addr=0, len=15. Assert `rst` after the 3rd beat → next cycle `out_valid`=0, `busy`=0, `req_ready`=1. A new request addr=9, len=0 then returns 0x1C.
- With `ROM_PARITY_EN`: read addr=1 (0x04) → `out_par`=1. Read addr=3 (0x0A) → `out_par`=0.

Source files
------------

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: synchronous lookup ROM with a burst read engine.
//
// A request (start address plus burst length minus one) is accepted on the
// req_valid/req_ready channel. The engine then streams consecutive ROM words
// on the out_valid/out_ready channel with backpressure. Addresses wrap modulo
// 2^ADDR_W. The first word appears one cycle after the request handshake.
//
// Parameters:
//   ADDR_W    address width, depth = 2^ADDR_W words
//   DATA_W    word width
//   LEN_W     burst length field width
//   INIT_FILE ROM image name; contents are mem[a] = (3*a + 1) mod 2^DATA_W
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  engine idle and able to accept a request
//   req_addr   burst start address
//   req_len    burst length minus one
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts the word
//   out_data   ROM word (0 when out_valid is low)
//   out_last   final word of the burst
//   out_par    even parity of out_data (only with ROM_PARITY_EN defined)
//   busy       a burst is in progress
//
// Optional feature macro: ROM_PARITY_EN adds the registered out_par output.

module rom_burst_reader #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LEN_W     = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef ROM_PARITY_EN
  output logic              out_par,
`endif
  output logic              busy
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;

  // ROM read port: in IDLE it looks up the requested start address, in STREAM
  // it looks ahead to the next word so the output register can load it on the
  // same edge as the beat handshake.
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_addr = (state_q == StIdle) ? req_addr : cur_q + ADDR_W'(1);
  end

  assign rd_data = DATA_W'(32'(rd_addr) * 32'd3 + 32'd1);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cur_d   = req_addr;
          rem_d   = req_len;
          data_d  = rd_data;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (rem_q == '0) begin
            // Clear the word so out_data reads 0 while idle.
            data_d  = '0;
            state_d = StIdle;
          end else begin
            cur_d  = cur_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            data_d = rd_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

`ifdef ROM_PARITY_EN
  logic par_q, par_d;

  // Parity travels with the word so it always matches out_data.
  always_comb begin
    par_d = ^data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_par = par_q;
`endif

  assign req_ready = (state_q == StIdle);
  assign out_valid = (state_q == StStream);
  assign busy      = (state_q == StStream);
  assign out_last  = (state_q == StStream) && (rem_q == '0);
  assign out_data  = data_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader with default parameters. Expected
// words come from the ROM formula (3*a + 1) mod 256 and burst bookkeeping is
// tracked as a beat index against the requested length.

module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_addr;
  logic [3:0] req_len;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef ROM_PARITY_EN
  logic       out_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rom_burst_reader #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .LEN_W    (4),
    .INIT_FILE("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
`ifdef ROM_PARITY_EN
    .out_par  (out_par),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_word(input int a);
    int w;
    w = (3 * (a % 16) + 1) % 256;
    return w[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
`ifdef ROM_PARITY_EN
    chk({tag, "_out_par"},   32'(out_par),   32'd0);
`endif
  endtask

  // mode 0: out_ready always high; 1: random out_ready;
  // 2: out_ready low for 3 cycles on the second beat.
  task automatic run_burst(input string tag, input int addr, input int len, input int mode);
    int  k;
    int  stall;
    int  cycles;
    logic rdy;
    @(negedge clk);
    chk_idle({tag, "_pre"});
    req_valid = 1'b1;
    req_addr  = 4'(addr);
    req_len   = 4'(len);
    out_ready = 1'($urandom_range(1, 0));
    k      = 0;
    stall  = 0;
    cycles = 0;
    while (k <= len) begin
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        n_cmp++;
        n_bad++;
        $error("FAIL %s_timeout: observed beat %0d expected beats %0d", tag, k, len + 1);
        break;
      end
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd1);
      chk({tag, "_out_data"},  32'(out_data),  32'(ref_word(addr + k)));
      chk({tag, "_out_last"},  32'(out_last),  32'(k == len));
`ifdef ROM_PARITY_EN
      chk({tag, "_out_par"},   32'(out_par),   32'(^ref_word(addr + k)));
`endif
      // Requests during a burst must be ignored.
      req_valid = 1'($urandom_range(1, 0));
      req_addr  = 4'($urandom);
      req_len   = 4'($urandom);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(99, 0) < 70);
        default: begin
          if (k == 1 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      out_ready = rdy;
      if (rdy) k++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    run_burst("single", 5, 0, 0);
    run_burst("seq",    0, 7, 0);
    run_burst("wrap",  14, 3, 0);
    run_burst("bp",     2, 2, 2);

    // Reset after the third beat discards the rest of the burst.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 4'd0;
    req_len   = 4'd15;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstmid_out_data", 32'(out_data), 32'(ref_word(i)));
      chk("rstmid_out_last", 32'(out_last), 32'd0);
      if (i == 2) rst = 1'b1;
    end
    @(negedge clk);
    chk_idle("rstmid_after");
    rst = 1'b0;
    run_burst("post_rst", 9, 0, 0);

    run_burst("par1", 1, 0, 0);
    run_burst("par3", 3, 0, 0);

    for (int n = 0; n < 25; n++) begin
      run_burst("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1);
    end

    @(negedge clk);
    chk_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
